// File: rtl/pe_sched_pkg.sv
// Shared types and default sizing for the PE array sequencer.
package pe_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_NUM_ROWS = 32;
    localparam int unsigned DEF_NUM_COLS = 16;
    localparam int unsigned DEF_AW       = 10;
    localparam int unsigned DEF_CNT_W    = 10;
    localparam int unsigned DEF_OUT_LAT  = DEF_NUM_ROWS + DEF_NUM_COLS - 1;

endpackage

// File: rtl/pe_valid_delay.sv
// Enable-gated 1-bit delay line tracking which array cycles carry a vector.
module pe_valid_delay #(
    parameter int unsigned DEPTH = 48
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    // Shift only when enabled so the line freezes together with the array.
    always_ff @(posedge CLK) begin
        if (RESET)
            sr <= '0;
        else if (en)
            sr <= {sr[DEPTH-2:0], d};
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/pe_array_sched.sv
// Job sequencer for the weight-stationary PE array: weight load, activation
// streaming and output write-back, with a global stall freeze.
module pe_array_sched
    import pe_sched_pkg::*;
#(
    parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
    parameter int unsigned NUM_COLS = DEF_NUM_COLS,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned OUT_LAT  = NUM_ROWS + NUM_COLS - 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [AW-1:0]    w_base,
    input  logic [AW-1:0]    a_base,
    input  logic [AW-1:0]    o_base,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_rd_addr,
    output logic             a_rd_en,
    output logic [AW-1:0]    a_rd_addr,
    output logic             arr_en,
    output logic             arr_w_en,
    output logic             o_wr_en,
    output logic [AW-1:0]    o_wr_addr
);

    localparam int unsigned RW = $clog2(NUM_ROWS + 1);

    state_t           state, state_n;
    logic             accept;
    logic [AW-1:0]    w_base_q, a_base_q, o_base_q;
    logic [CNT_W-1:0] m_q, acnt, ocnt;
    logic [RW-1:0]    rcnt;
    logic             w_pend;
    logic             pipe_out;
    logic [AW-1:0]    w_addr_c, a_addr_c, o_addr_c;
    logic [AW-1:0]    w_addr_q, a_addr_q, o_addr_q;

    assign w_addr_c = w_base_q + AW'(NUM_ROWS - 1) - AW'(rcnt);
    assign a_addr_c = a_base_q + AW'(acnt);
    assign o_addr_c = o_base_q + AW'(ocnt);

    // Addresses follow the live counter while strobing, else show the last one.
    assign w_rd_addr = w_rd_en ? w_addr_c : w_addr_q;
    assign a_rd_addr = a_rd_en ? a_addr_c : a_addr_q;
    assign o_wr_addr = o_wr_en ? o_addr_c : o_addr_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and strobe decode; stall masks every strobe in active states.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        w_rd_en  = 1'b0;
        a_rd_en  = 1'b0;
        arr_en   = 1'b0;
        arr_w_en = 1'b0;
        o_wr_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = LOAD_W;
                end
            end
            LOAD_W: begin
                if (!stall) begin
                    w_rd_en  = (rcnt != RW'(NUM_ROWS));
                    arr_w_en = w_pend;
                    if (w_pend && rcnt == RW'(NUM_ROWS))
                        state_n = (m_q == '0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (!stall) begin
                    arr_en  = 1'b1;
                    a_rd_en = 1'b1;
                    o_wr_en = pipe_out;
                    if (acnt == m_q - CNT_W'(1))
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    arr_en  = 1'b1;
                    o_wr_en = pipe_out;
                    if (pipe_out && ocnt == m_q - CNT_W'(1))
                        state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Job parameters, counters and held addresses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            w_base_q <= '0;
            a_base_q <= '0;
            o_base_q <= '0;
            m_q      <= '0;
            rcnt     <= '0;
            acnt     <= '0;
            ocnt     <= '0;
            w_pend   <= 1'b0;
            w_addr_q <= '0;
            a_addr_q <= '0;
            o_addr_q <= '0;
        end else begin
            if (accept) begin
                w_base_q <= w_base;
                a_base_q <= a_base;
                o_base_q <= o_base;
                m_q      <= num_vec;
                rcnt     <= '0;
                acnt     <= '0;
                ocnt     <= '0;
            end
            // Read data is held by the SRAM, so a stalled weight shift just waits.
            if (!stall)
                w_pend <= w_rd_en;
            if (w_rd_en) begin
                rcnt     <= rcnt + RW'(1);
                w_addr_q <= w_addr_c;
            end
            if (a_rd_en) begin
                acnt     <= acnt + CNT_W'(1);
                a_addr_q <= a_addr_c;
            end
            if (o_wr_en) begin
                ocnt     <= ocnt + CNT_W'(1);
                o_addr_q <= o_addr_c;
            end
        end
    end

    pe_valid_delay #(
        .DEPTH(OUT_LAT + 1)
    ) u_valid (
        .CLK  (CLK),
        .RESET(RESET),
        .en   (!stall),
        .d    (a_rd_en),
        .q    (pipe_out)
    );

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched (NUM_ROWS=4, OUT_LAT=7, AW=8).
// Events are logged as cycle*256+address, cycle 0 = start sampled.
module tb_pe_array_sched;

    localparam int unsigned NR  = 4;
    localparam int unsigned AWB = 8;
    localparam int unsigned CW  = 8;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           start;
    logic [CW-1:0]  num_vec;
    logic [AWB-1:0] w_base, a_base, o_base;
    logic           stall;
    logic           busy, done, w_rd_en, a_rd_en, arr_en, arr_w_en, o_wr_en;
    logic [AWB-1:0] w_rd_addr, a_rd_addr, o_wr_addr;

    pe_array_sched #(
        .NUM_ROWS(NR),
        .NUM_COLS(4),
        .AW      (AWB),
        .CNT_W   (CW),
        .OUT_LAT (7)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .num_vec  (num_vec),
        .w_base   (w_base),
        .a_base   (a_base),
        .o_base   (o_base),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .w_rd_en  (w_rd_en),
        .w_rd_addr(w_rd_addr),
        .a_rd_en  (a_rd_en),
        .a_rd_addr(a_rd_addr),
        .arr_en   (arr_en),
        .arr_w_en (arr_w_en),
        .o_wr_en  (o_wr_en),
        .o_wr_addr(o_wr_addr)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int q_w[$], q_aw[$], q_a[$], q_o[$], q_d[$];
    int e_w[$], e_aw[$], e_a[$], e_o[$], e_d[$];
    int arr_en_cnt;
    int first_idle;

    function automatic int ev(input int c, input int a);
        return c * 256 + a;
    endfunction

    function automatic logic [31:0] all_outs();
        return {1'b0, busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                arr_en, arr_w_en, o_wr_en, o_wr_addr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_list(input string tag, input int obs[$], input int exp[$]);
        chk({tag, "_count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
    endtask

    // One job: start at cycle 0, optional extra start pulses, stall window, reset.
    task automatic run_job(input logic [7:0] wb, input logic [7:0] ab, input logic [7:0] ob,
                           input int m, input int st_lo, input int st_hi,
                           input int s2a, input int s2b, input int rst_at, input int ncyc);
        q_w.delete(); q_aw.delete(); q_a.delete(); q_o.delete(); q_d.delete();
        arr_en_cnt = 0;
        first_idle = -1;
        w_base  = wb;
        a_base  = ab;
        o_base  = ob;
        num_vec = CW'(m);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge CLK);
            start = (c == 0 || c == s2a || c == s2b);
            stall = (c >= st_lo && c <= st_hi);
            RESET = (c == rst_at);
            #1;
            if (w_rd_en)  q_w.push_back(ev(c, int'(w_rd_addr)));
            if (arr_w_en) q_aw.push_back(ev(c, 0));
            if (a_rd_en)  q_a.push_back(ev(c, int'(a_rd_addr)));
            if (o_wr_en)  q_o.push_back(ev(c, int'(o_wr_addr)));
            if (done)     q_d.push_back(ev(c, 0));
            if (arr_en)   arr_en_cnt++;
            if (c > 0 && !busy && first_idle < 0) first_idle = c;
            if (c == rst_at + 1) chk("midjob_reset_outputs", all_outs(), 32'h0);
        end
        start = 1'b0;
        stall = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic set_load_exp(input int off);
        e_w  = '{ev(1, 'h13), ev(2 + off, 'h12), ev(3 + off, 'h11), ev(4 + off, 'h10)};
        e_aw = '{ev(2 + off, 0), ev(3 + off, 0), ev(4 + off, 0), ev(5 + off, 0)};
    endtask

    initial begin
        RESET   = 1'b1;
        start   = 1'b1;
        stall   = 1'b0;
        num_vec = CW'(3);
        w_base  = 8'h10;
        a_base  = 8'h40;
        o_base  = 8'h80;

        // Reset held with start high: everything quiet, no transition.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("reset_outputs_%0d", i), all_outs(), 32'h0);
        end
        @(negedge CLK);
        RESET = 1'b0;
        start = 1'b0;
        #1;
        chk("reset_release_idle", busy, 1'b0);
        @(negedge CLK);
        chk("idle_no_start", busy, 1'b0);

        // Basic job, M=3.
        run_job(8'h10, 8'h40, 8'h80, 3, 1000, -1, -1, -1, 1000, 22);
        set_load_exp(0);
        e_a = '{ev(6, 'h40), ev(7, 'h41), ev(8, 'h42)};
        e_o = '{ev(14, 'h80), ev(15, 'h81), ev(16, 'h82)};
        e_d = '{ev(17, 0)};
        check_list("t2_wrd", q_w, e_w);
        check_list("t2_arrw", q_aw, e_aw);
        check_list("t2_ard", q_a, e_a);
        check_list("t2_owr", q_o, e_o);
        check_list("t2_done", q_d, e_d);
        chk("t2_arr_en_cycles", arr_en_cnt, 11);
        chk("t2_idle_cycle", first_idle, 18);

        // Stall on cycles 7-8: the valid pipe freezes with the array, so
        // vector 0 slips by the stall length along with vectors 1 and 2.
        run_job(8'h10, 8'h40, 8'h80, 3, 7, 8, -1, -1, 1000, 24);
        e_a = '{ev(6, 'h40), ev(9, 'h41), ev(10, 'h42)};
        e_o = '{ev(16, 'h80), ev(17, 'h81), ev(18, 'h82)};
        e_d = '{ev(19, 0)};
        check_list("t3_wrd", q_w, e_w);
        check_list("t3_ard", q_a, e_a);
        check_list("t3_owr", q_o, e_o);
        check_list("t3_done", q_d, e_d);
        chk("t3_arr_en_cycles", arr_en_cnt, 11);

        // M=0: weight load only.
        run_job(8'h10, 8'h40, 8'h80, 0, 1000, -1, -1, -1, 1000, 10);
        e_a.delete();
        e_o.delete();
        e_d = '{ev(6, 0)};
        check_list("t4_wrd", q_w, e_w);
        check_list("t4_arrw", q_aw, e_aw);
        check_list("t4_ard", q_a, e_a);
        check_list("t4_owr", q_o, e_o);
        check_list("t4_done", q_d, e_d);
        chk("t4_arr_en_cycles", arr_en_cnt, 0);
        chk("t4_idle_cycle", first_idle, 7);

        // Start pulses mid-job are ignored.
        run_job(8'h10, 8'h40, 8'h80, 3, 1000, -1, 3, 17, 1000, 22);
        e_a = '{ev(6, 'h40), ev(7, 'h41), ev(8, 'h42)};
        e_o = '{ev(14, 'h80), ev(15, 'h81), ev(16, 'h82)};
        e_d = '{ev(17, 0)};
        check_list("t5_wrd", q_w, e_w);
        check_list("t5_ard", q_a, e_a);
        check_list("t5_owr", q_o, e_o);
        check_list("t5_done", q_d, e_d);
        chk("t5_idle_cycle", first_idle, 18);

        // Stall during weight load (cycle 2) delays the shift and everything after.
        run_job(8'h10, 8'h40, 8'h80, 3, 2, 2, -1, -1, 1000, 22);
        set_load_exp(1);
        e_a = '{ev(7, 'h40), ev(8, 'h41), ev(9, 'h42)};
        e_o = '{ev(15, 'h80), ev(16, 'h81), ev(17, 'h82)};
        e_d = '{ev(18, 0)};
        check_list("tw_wrd", q_w, e_w);
        check_list("tw_arrw", q_aw, e_aw);
        check_list("tw_ard", q_a, e_a);
        check_list("tw_owr", q_o, e_o);
        check_list("tw_done", q_d, e_d);

        // Reset at cycle 9, then a job whose output addresses wrap.
        run_job(8'h10, 8'h40, 8'h80, 3, 1000, -1, -1, -1, 9, 10);
        chk("t6_idle_after_reset", first_idle, 10);
        run_job(8'h10, 8'h40, 8'hFE, 3, 1000, -1, -1, -1, 1000, 22);
        set_load_exp(0);
        e_o = '{ev(14, 'hFE), ev(15, 'hFF), ev(16, 'h00)};
        e_d = '{ev(17, 0)};
        check_list("t6_wrd", q_w, e_w);
        check_list("t6_owr", q_o, e_o);
        check_list("t6_done", q_d, e_d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
